seq_det_param: RTL and testbench
================================

Name: seq_det_param

Overview:
- Parametrised serial sequence detector.
- Compares a 1-bit input stream against a runtime-programmable, maskable pattern of PATTERN_LEN bits.
- Supports overlapping and non-overlapping detection, sample-valid gating, and a saturating match counter.
- Sits on the serial input path as a drop-in successor to the fixed-pattern detectors. The match pulse and counter feed downstream control and status logic.

Parameters:
- PATTERN_LEN, 3: pattern length N in bits; legal range 2..32.
- PATTERN, 3'b101: reset value of the pattern register. MSB is the earliest-received bit.
- CNT_W, 8: match counter width; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`. The sample is consumed only when this is high.
- overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping. Sampled each valid cycle.
- cfg_load  input  1  loads cfg_pattern and cfg_mask, and flushes history.
- cfg_pattern  input  PATTERN_LEN  new pattern value. MSB is the earliest bit.
- cfg_mask  input  PATTERN_LEN  per-bit compare enable; 1 = compare, 0 = don't care.
- cnt_clr  input  1  synchronous clear of match_cnt.
- out  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (async assert, any time): pat=PATTERN, mask=all ones, hist=0, fill=0, out=0, match_cnt=0. Reset mid-sequence discards all partial history.
- State:
  - hist: N-bit shift register.
  - fill: 0..N, number of valid bits held in hist.
- Per valid sample (in_valid=1, cfg_load=0):
  - nh = {hist[N-2:0], in}
  - nf = min(fill+1, N)
  - match = (nf==N) && (((nh ^ pat) & mask) == 0)
- Registered update on the same edge:
  - hist <= nh
  - out <= match
  - fill <= (match && !overlap_en) ? 0 : nf
- Latency: out rises on the clock edge that samples the final pattern bit, and is visible for exactly that one following cycle.
- in_valid=0: hist and fill hold; out <= 0. Gaps do not break a partial sequence.
- Overlap mode: after a match, history is kept. The next match can occur on the very next valid sample if the pattern allows it.
- Non-overlap mode: after a match, fill <= 0. The next match needs N fresh valid samples.
- overlap_en changing mid-stream takes effect on the next valid sample. No flush occurs.
- cfg_load=1:
  - pat <= cfg_pattern; mask <= cfg_mask; fill <= 0; out <= 0.
  - A simultaneous valid sample is dropped (cfg_load has priority).
- All-zero mask: every valid sample with nf==N matches.
- Counter:
  - On match: match_cnt increments, saturating at 2^CNT_W-1; no wrap.
  - cnt_clr=1: match_cnt <= 0. Clear has priority over a simultaneous match (result 0, not 1). out still pulses.
- No combinational path from inputs to outputs.

Test Plan:
1. Defaults (N=3, pattern 101), overlap_en=1, valid stream 1,0,1,0,1 -> out pulses after the 3rd and 5th samples; match_cnt=2.
2. Same stream with overlap_en=0 -> single pulse after the 3rd sample only; match_cnt=1. Then stream 1,0,1,1,0,1 -> pulses after the 3rd and 6th samples.
3. Stream 1, (in_valid=0 x2), 0, (in_valid=0), 1 -> one pulse after the last valid sample; out=0 during gaps.
4. cfg_load with cfg_pattern=3'b111, cfg_mask=3'b101, then stream 1,1,1 and 1,0,1 -> both match. cfg_load asserted together with a valid sample -> that sample is ignored; fill restarts at 0.
5. Stream 1,0 then rst pulse, then 1 -> no match (fill=1 after reset). Continuing 0,1 -> match.
6. CNT_W=2, 5 matches -> match_cnt saturates at 3. cnt_clr on the same cycle as a match -> match_cnt=0, out=1.

Source files
------------

// File: rtl/seq_det_param.sv
// Serial sequence detector with a runtime-programmable, maskable pattern,
// overlap/non-overlap modes, sample-valid gating and a saturating match counter.
module seq_det_param #(
   parameter int                     PATTERN_LEN = 3,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b101,
   parameter int                     CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in,
   input  logic                   in_valid,
   input  logic                   overlap_en,
   input  logic                   cfg_load,
   input  logic [PATTERN_LEN-1:0] cfg_pattern,
   input  logic [PATTERN_LEN-1:0] cfg_mask,
   input  logic                   cnt_clr,
   output logic                   out,
   output logic [CNT_W-1:0]       match_cnt
);

   localparam int FW = $clog2(PATTERN_LEN + 1);

   logic [PATTERN_LEN-1:0] pat;
   logic [PATTERN_LEN-1:0] mask;
   logic [PATTERN_LEN-1:0] hist;
   logic [FW-1:0]          fill;

   logic [PATTERN_LEN-1:0] nh;
   logic [FW-1:0]          nf;
   logic                   hit;
   logic                   take;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      nh   = {hist[PATTERN_LEN-2:0], in};
      nf   = (fill == FW'(PATTERN_LEN)) ? fill : fill + 1'b1;
      hit  = (nf == FW'(PATTERN_LEN)) && (((nh ^ pat) & mask) == '0);
      // A sample arriving together with cfg_load is dropped.
      take = in_valid && !cfg_load;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat       <= PATTERN;
         mask      <= '1;
         hist      <= '0;
         fill      <= '0;
         out       <= 1'b0;
         match_cnt <= '0;
      end else begin
         out <= 1'b0;
         if (cfg_load) begin
            pat  <= cfg_pattern;
            mask <= cfg_mask;
            fill <= '0;
         end else if (in_valid) begin
            hist <= nh;
            out  <= hit;
            fill <= (hit && !overlap_en) ? '0 : nf;
         end

         // Clear wins over a coincident match; the pulse on out is unaffected.
         if (cnt_clr)
            match_cnt <= '0;
         else if (take && hit)
            match_cnt <= sat_inc(match_cnt);
      end
   end

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param (N=3, reset pattern 101, 2-bit counter).
module tb_seq_det_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       in_valid;
   logic       overlap_en;
   logic       cfg_load;
   logic [2:0] cfg_pattern;
   logic [2:0] cfg_mask;
   logic       cnt_clr;
   logic       out;
   logic [1:0] match_cnt;

   int checks = 0;
   int errors = 0;

   seq_det_param #(.PATTERN_LEN(3), .PATTERN(3'b101), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap_en(overlap_en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
      .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock with the given sample; out is then checked against exp_out.
   task automatic smp(input string tag, input logic v, input logic b, input logic exp_out);
      in_valid = v;
      in       = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
      cfg_load = 1'b0;
      chk(tag, {31'd0, out}, {31'd0, exp_out});
   endtask

   task automatic load(input string tag, input logic [2:0] p, input logic [2:0] m);
      cfg_pattern = p;
      cfg_mask    = m;
      cfg_load    = 1'b1;
      smp(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in = 1'b0; in_valid = 1'b0; overlap_en = 1'b1;
      cfg_load = 1'b0; cfg_pattern = 3'b000; cfg_mask = 3'b111; cnt_clr = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_out", {31'd0, out}, 32'd0);
      chk("reset_cnt", {30'd0, match_cnt}, 32'd0);
      rst = 1'b0;

      // Overlapping detection of 101 in 1,0,1,0,1
      overlap_en = 1'b1;
      smp("t1_s1", 1, 1, 0);
      smp("t1_s2", 1, 0, 0);
      smp("t1_s3", 1, 1, 1);
      smp("t1_s4", 1, 0, 0);
      smp("t1_s5", 1, 1, 1);
      chk("t1_cnt", {30'd0, match_cnt}, 32'd2);

      // Non-overlapping detection, history flushed by reloading the pattern
      cnt_clr = 1'b1;
      load("t2_load", 3'b101, 3'b111);
      chk("t2_clr", {30'd0, match_cnt}, 32'd0);
      overlap_en = 1'b0;
      smp("t2_s1", 1, 1, 0);
      smp("t2_s2", 1, 0, 0);
      smp("t2_s3", 1, 1, 1);
      smp("t2_s4", 1, 0, 0);
      smp("t2_s5", 1, 1, 0);
      chk("t2_cnt", {30'd0, match_cnt}, 32'd1);
      load("t2_reload", 3'b101, 3'b111);
      smp("t2b_s1", 1, 1, 0);
      smp("t2b_s2", 1, 0, 0);
      smp("t2b_s3", 1, 1, 1);
      smp("t2b_s4", 1, 1, 0);
      smp("t2b_s5", 1, 0, 0);
      smp("t2b_s6", 1, 1, 1);
      chk("t2b_cnt", {30'd0, match_cnt}, 32'd3);

      // Invalid gaps hold partial history
      cnt_clr = 1'b1;
      load("t3_load", 3'b101, 3'b111);
      overlap_en = 1'b1;
      smp("t3_v1", 1, 1, 0);
      smp("t3_g1", 0, 0, 0);
      smp("t3_g2", 0, 1, 0);
      smp("t3_v2", 1, 0, 0);
      smp("t3_g3", 0, 1, 0);
      smp("t3_v3", 1, 1, 1);
      smp("t3_after", 0, 1, 0);
      chk("t3_cnt", {30'd0, match_cnt}, 32'd1);

      // Masked pattern 1x1 and dropped sample under cfg_load
      load("t4_load", 3'b111, 3'b101);
      overlap_en = 1'b0;
      smp("t4_a1", 1, 1, 0);
      smp("t4_a2", 1, 1, 0);
      smp("t4_a3", 1, 1, 1);
      smp("t4_b1", 1, 1, 0);
      smp("t4_b2", 1, 0, 0);
      smp("t4_b3", 1, 1, 1);
      chk("t4_cnt", {30'd0, match_cnt}, 32'd3);
      cfg_pattern = 3'b111; cfg_mask = 3'b101; cfg_load = 1'b1;
      smp("t4_ld_valid", 1, 1, 0);
      smp("t4_c1", 1, 1, 0);
      smp("t4_c2", 1, 1, 0);
      smp("t4_c3", 1, 1, 1);

      // All-zero mask: every full window matches
      load("t4m_load", 3'b010, 3'b000);
      overlap_en = 1'b1;
      smp("t4m_s1", 1, 1, 0);
      smp("t4m_s2", 1, 0, 0);
      smp("t4m_s3", 1, 1, 1);
      smp("t4m_s4", 1, 0, 1);

      // Asynchronous reset mid-sequence discards history and config
      overlap_en = 1'b1;
      smp("t5_s1", 1, 1, 1);
      smp("t5_s2", 1, 0, 1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_out", {31'd0, out}, 32'd0);
      chk("t5_rst_cnt", {30'd0, match_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      smp("t5_s3", 1, 1, 0);
      smp("t5_s4", 1, 0, 0);
      smp("t5_s5", 1, 1, 1);
      chk("t5_cnt", {30'd0, match_cnt}, 32'd1);

      // Saturation of the 2-bit counter, then clear racing a match
      smp("t6_s1", 1, 0, 0);
      smp("t6_s2", 1, 1, 1);
      chk("t6_cnt2", {30'd0, match_cnt}, 32'd2);
      smp("t6_s3", 1, 0, 0);
      smp("t6_s4", 1, 1, 1);
      smp("t6_s5", 1, 0, 0);
      smp("t6_s6", 1, 1, 1);
      chk("t6_sat", {30'd0, match_cnt}, 32'd3);
      smp("t6_s7", 1, 0, 0);
      cnt_clr = 1'b1;
      smp("t6_clr_hit", 1, 1, 1);
      chk("t6_clr_cnt", {30'd0, match_cnt}, 32'd0);
      smp("t6_s9", 1, 0, 0);
      smp("t6_s10", 1, 1, 1);
      chk("t6_cnt_after", {30'd0, match_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
